// File: rtl/e_mem_compress_wr.sv
`default_nettype none
// ============================================================================
// Module   : e_mem_compress_wr
// Purpose  : Write-side producer for the layer-E memory of a layered LDPC
//            decoder. Collects the Wc check-node messages of one row (one per
//            accepted cycle), tracks min1 / min2 / index-of-min1 and the
//            per-message sign bits, then issues a single write of the packed
//            compressed word {min1, min2, idx, signs} to the E memory.
// Ports    :
//   clk        in   1          clock, rising edge
//   rst        in   1          asynchronous reset, active low
//   in_valid   in   1          in_msg valid
//   in_ready   out  1          message can be accepted this cycle
//   in_msg     in   W          check-node message, two's complement
//   in_addr    in   ADDRWIDTH  row address, sampled with message 0 only
//   e_wr       out  1          E memory write strobe
//   e_wr_addr  out  ADDRWIDTH  E memory write address (registered, held)
//   e_din      out  ECOMPSIZE  packed word (registered, held)
//   row_done   out  1          one-cycle pulse coincident with e_wr
//   busy       out  1          row partially collected or being written
// Revision : 1.0 - initial release
// ============================================================================
module e_mem_compress_wr #(
    parameter int DEPTH     = 512,
    parameter int ADDRWIDTH = 9,
    parameter int Wc        = 32,
    parameter int Wcbits    = 5,
    parameter int W         = 6,
    parameter int Wabs      = W - 1,
    parameter int ECOMPSIZE = 2 * Wabs + Wcbits + Wc
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_msg,
    input  logic [ADDRWIDTH-1:0] in_addr,
    output logic                 e_wr,
    output logic [ADDRWIDTH-1:0] e_wr_addr,
    output logic [ECOMPSIZE-1:0] e_din,
    output logic                 row_done,
    output logic                 busy
);

    // The address space must cover the memory depth.
    if ((2 ** ADDRWIDTH) < DEPTH) begin : g_depth_check
        $error("e_mem_compress_wr: ADDRWIDTH too small for DEPTH");
    end

    localparam logic [0:0]        S_COLLECT = 1'b0;
    localparam logic [0:0]        S_WRITE   = 1'b1;
    localparam logic [Wabs-1:0]   C_MAG_MAX = '1;
    localparam logic [Wcbits-1:0] C_LAST    = Wcbits'(Wc - 1);

    logic [0:0]           state_q, state_d;
    logic                 init_q;
    logic [Wcbits-1:0]    count_q, count_d;
    logic [Wabs-1:0]      min1_q, min1_d;
    logic [Wabs-1:0]      min2_q, min2_d;
    logic [Wcbits-1:0]    idx_q, idx_d;
    logic [Wc-1:0]        signs_q, signs_d;
    logic [ADDRWIDTH-1:0] addr_q, addr_d;
    logic [ADDRWIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ECOMPSIZE-1:0] din_q, din_d;

    logic                 w_accept;
    logic                 w_sign;
    logic [W-1:0]         w_neg;
    logic [Wabs-1:0]      w_mag;
    logic [Wabs-1:0]      w_min1_base;
    logic [Wabs-1:0]      w_min2_base;
    logic [Wcbits-1:0]    w_idx_base;
    logic [Wc-1:0]        w_signs_base;
    logic [ADDRWIDTH-1:0] w_row_addr;

    assign w_accept = in_valid & in_ready;

    // Magnitude with saturation: negating the most negative value overflows
    // back to a negative number, which is clamped to the largest magnitude.
    assign w_sign = in_msg[W-1];
    assign w_neg  = ~in_msg + W'(1);
    assign w_mag  = w_sign ? (w_neg[W-1] ? C_MAG_MAX : w_neg[Wabs-1:0])
                           : in_msg[Wabs-1:0];

    // Message 0 starts from a clean slate rather than the previous row state,
    // so no explicit clear cycle is needed between rows.
    assign w_min1_base  = (count_q == '0) ? C_MAG_MAX : min1_q;
    assign w_min2_base  = (count_q == '0) ? C_MAG_MAX : min2_q;
    assign w_idx_base   = (count_q == '0) ? '0 : idx_q;
    assign w_signs_base = (count_q == '0) ? '0 : signs_q;
    assign w_row_addr   = (count_q == '0) ? in_addr : addr_q;

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        count_d   = count_q;
        min1_d    = min1_q;
        min2_d    = min2_q;
        idx_d     = idx_q;
        signs_d   = signs_q;
        addr_d    = addr_q;
        wr_addr_d = wr_addr_q;
        din_d     = din_q;
        if (w_accept) begin
            addr_d  = w_row_addr;
            min1_d  = w_min1_base;
            min2_d  = w_min2_base;
            idx_d   = w_idx_base;
            signs_d = w_signs_base;
            // Strict compares: on a tie the earlier index keeps min1.
            if (w_mag < w_min1_base) begin
                min2_d = w_min1_base;
                min1_d = w_mag;
                idx_d  = count_q;
            end else if (w_mag < w_min2_base) begin
                min2_d = w_mag;
            end
            signs_d[count_q] = w_sign;
            if (count_q == C_LAST) begin
                count_d   = '0;
                // Output word is captured on the final accept so that it is
                // valid during the write cycle and held afterwards.
                wr_addr_d = w_row_addr;
                din_d     = {min1_d, min2_d, idx_d, signs_d};
            end else begin
                count_d = count_q + Wcbits'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_COLLECT: if (w_accept && (count_q == C_LAST)) state_d = S_WRITE;
            S_WRITE:   state_d = S_COLLECT;
            default:   state_d = S_COLLECT;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        // init_q holds in_ready low until the first edge after reset release.
        in_ready = init_q && (state_q == S_COLLECT);
        e_wr     = (state_q == S_WRITE);
        row_done = (state_q == S_WRITE);
        busy     = (count_q != '0) || (state_q == S_WRITE);
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_q    <= 1'b0;
            count_q   <= '0;
            min1_q    <= '1;
            min2_q    <= '1;
            idx_q     <= '0;
            signs_q   <= '0;
            addr_q    <= '0;
            wr_addr_q <= '0;
            din_q     <= '0;
        end else begin
            init_q    <= 1'b1;
            count_q   <= count_d;
            min1_q    <= min1_d;
            min2_q    <= min2_d;
            idx_q     <= idx_d;
            signs_q   <= signs_d;
            addr_q    <= addr_d;
            wr_addr_q <= wr_addr_d;
            din_q     <= din_d;
        end
    end

    assign e_wr_addr = wr_addr_q;
    assign e_din     = din_q;

endmodule
`default_nettype wire

// File: tb/tb_e_mem_compress_wr.sv
`default_nettype none
// ============================================================================
// Module   : tb_e_mem_compress_wr
// Purpose  : Directed self-checking bench for e_mem_compress_wr with
//            hand-computed packed words for each row scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_e_mem_compress_wr;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_msg;
    logic [8:0]  in_addr;
    logic        e_wr;
    logic [8:0]  e_wr_addr;
    logic [46:0] e_din;
    logic        row_done;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [5:0] msgs  [32];
    logic [5:0] msgs2 [32];

    e_mem_compress_wr dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_msg    (in_msg),
        .in_addr   (in_addr),
        .e_wr      (e_wr),
        .e_wr_addr (e_wr_addr),
        .e_din     (e_din),
        .row_done  (row_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic [4:0] m1, input logic [4:0] m2,
                                         input logic [4:0] ix, input logic [31:0] s);
        return 64'({m1, m2, ix, s});
    endfunction

    task automatic fill(input int sc);
        for (int i = 0; i < 32; i++) begin
            case (sc)
                1:       msgs[i] = 6'd10;
                2:       msgs[i] = 6'd31;
                3:       msgs[i] = 6'd20;
                default: msgs[i] = 6'h3F;   // -1
            endcase
        end
        case (sc)
            1: begin msgs[7] = 6'h3D; msgs[20] = 6'd5; end            // -3, +5
            2: begin msgs[0] = 6'h20; end                              // -32
            3: begin msgs[4] = 6'd2; msgs[9] = 6'd2; msgs[12] = 6'h3E; end // -2
            default: ;
        endcase
    endtask

    // Sends one full row from msgs; called and returns on a falling edge.
    // On return the DUT should be in its write cycle.
    task automatic send_row(input logic [8:0] addr, input int idle_pct);
        for (int k = 0; k < 32; k++) begin
            for (int g = 0; g < 4 && $urandom_range(0, 99) < idle_pct; g++) begin
                in_valid = 1'b0;
                in_msg   = 6'($urandom);
                in_addr  = 9'($urandom);
                @(posedge clk); @(negedge clk);
                chk("no_early_wr_gap", 64'(e_wr), 64'd0);
            end
            in_valid = 1'b1;
            in_msg   = msgs[k];
            in_addr  = (k == 0) ? addr : 9'($urandom);
            chk("ready_in_row", 64'(in_ready), 64'd1);
            @(posedge clk); @(negedge clk);
            if (k < 31) chk("no_early_wr", 64'(e_wr), 64'd0);
        end
        in_valid = 1'b0;
    endtask

    task automatic check_write(input string tag, input logic [8:0] addr, input logic [63:0] din);
        chk({tag, "_e_wr"},     64'(e_wr),      64'd1);
        chk({tag, "_row_done"}, 64'(row_done),  64'd1);
        chk({tag, "_addr"},     64'(e_wr_addr), 64'(addr));
        chk({tag, "_din"},      64'(e_din),     din);
        chk({tag, "_busy"},     64'(busy),      64'd1);
        chk({tag, "_ready0"},   64'(in_ready),  64'd0);
        @(posedge clk); @(negedge clk);
        chk({tag, "_wr_off"},    64'(e_wr),      64'd0);
        chk({tag, "_done_off"},  64'(row_done),  64'd0);
        chk({tag, "_din_hold"},  64'(e_din),     din);
        chk({tag, "_addr_hold"}, 64'(e_wr_addr), 64'(addr));
        chk({tag, "_idle"},      64'(busy),      64'd0);
        chk({tag, "_ready1"},    64'(in_ready),  64'd1);
    endtask

    initial begin
        int k, row, nwr, cyc;
        int wr_cyc [2];
        logic exp_wr, will_acc;

        // ---------------- reset ----------------
        rst      = 1'b0;
        in_valid = 1'b0;
        in_msg   = '0;
        in_addr  = '0;
        #12;
        chk("rst_e_wr",     64'(e_wr),      64'd0);
        chk("rst_row_done", 64'(row_done),  64'd0);
        chk("rst_addr",     64'(e_wr_addr), 64'd0);
        chk("rst_din",      64'(e_din),     64'd0);
        chk("rst_busy",     64'(busy),      64'd0);
        chk("rst_ready",    64'(in_ready),  64'd0);
        @(negedge clk);
        rst = 1'b1;
        chk("ready_before_edge", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("ready_after_edge", 64'(in_ready), 64'd1);

        // ---------------- 1: basic row ----------------
        fill(1);
        send_row(9'd5, 0);
        check_write("s1", 9'd5, pack(5'd3, 5'd5, 5'd7, 32'h00000080));

        // ---------------- 2: saturation ----------------
        fill(2);
        send_row(9'd17, 0);
        check_write("s2", 9'd17, pack(5'd31, 5'd31, 5'd0, 32'h00000001));

        // ---------------- 3: ties ----------------
        fill(3);
        send_row(9'd300, 0);
        check_write("s3", 9'd300, pack(5'd2, 5'd2, 5'd4, 32'h00001000));

        // ---------------- 4: idle gaps ----------------
        fill(1);
        send_row(9'd5, 40);
        check_write("s4", 9'd5, pack(5'd3, 5'd5, 5'd7, 32'h00000080));

        // ---------------- 5: reset mid-row ----------------
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_msg   = msgs[i];
            in_addr  = 9'd100;
            @(posedge clk); @(negedge clk);
        end
        in_valid = 1'b0;
        chk("s5_busy_partial", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        chk("s5_rst_busy",  64'(busy),      64'd0);
        chk("s5_rst_ready", 64'(in_ready),  64'd0);
        chk("s5_rst_din",   64'(e_din),     64'd0);
        chk("s5_rst_addr",  64'(e_wr_addr), 64'd0);
        @(negedge clk);
        chk("s5_rst_no_wr", 64'(e_wr), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("s5_ready", 64'(in_ready), 64'd1);
        chk("s5_no_wr", 64'(e_wr),     64'd0);
        fill(5);
        send_row(9'd9, 0);
        check_write("s5", 9'd9, pack(5'd1, 5'd1, 5'd0, 32'hFFFFFFFF));

        // ---------------- 6: back-to-back rows ----------------
        fill(3);
        for (int i = 0; i < 32; i++) msgs2[i] = msgs[i];
        fill(1);
        k = 0; row = 0; nwr = 0; cyc = 0; exp_wr = 1'b0;
        wr_cyc[0] = 0; wr_cyc[1] = 0;
        in_valid = 1'b1;
        while (nwr < 2 && cyc < 100) begin
            chk("s6_wr",    64'(e_wr),     64'(exp_wr));
            chk("s6_ready", 64'(in_ready), 64'(!exp_wr));
            if (e_wr) begin
                if (nwr < 2) begin
                    wr_cyc[nwr] = cyc;
                    if (nwr == 0) begin
                        chk("s6_addr0", 64'(e_wr_addr), 64'd6);
                        chk("s6_din0",  64'(e_din), pack(5'd3, 5'd5, 5'd7, 32'h00000080));
                    end else begin
                        chk("s6_addr1", 64'(e_wr_addr), 64'd7);
                        chk("s6_din1",  64'(e_din), pack(5'd2, 5'd2, 5'd4, 32'h00001000));
                    end
                end
                nwr++;
            end
            will_acc = !exp_wr && (row < 2);
            if (row < 2) begin
                in_msg  = (row == 0) ? msgs[k] : msgs2[k];
                in_addr = (k == 0) ? ((row == 0) ? 9'd6 : 9'd7) : 9'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            exp_wr = will_acc && (k == 31);
            if (will_acc) begin
                k++;
                if (k == 32) begin
                    k = 0;
                    row++;
                end
            end
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk("s6_num_writes", 64'(nwr), 64'd2);
        chk("s6_spacing",    64'(wr_cyc[1] - wr_cyc[0]), 64'd33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
